// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: button order, keymap entry
// layout and the keymap match rule.
package arcade_input_pkg;

  typedef enum int {
    BTN_RIGHT = 0,
    BTN_LEFT  = 1,
    BTN_DOWN  = 2,
    BTN_UP    = 3,
    BTN_FIRE  = 4,
    BTN_JUMP  = 5,
    BTN_START = 6,
    BTN_COIN  = 7
  } btn_idx_e;

  localparam int ME_VALID     = 15;
  localparam int ME_EXT_ANY   = 14;
  localparam int ME_CODE_HI   = 13;
  localparam int ME_CODE_LO   = 5;
  localparam int ME_PLAYER_HI = 4;
  localparam int ME_PLAYER_LO = 3;
  localparam int ME_BTN_HI    = 2;
  localparam int ME_BTN_LO    = 0;

  typedef struct packed {
    logic       valid;
    logic       ext_any;
    logic [8:0] code;
    logic [1:0] player;
    logic [2:0] button;
  } map_entry_t;

  function automatic map_entry_t unpack_entry(logic [15:0] d);
    map_entry_t e;
    e.valid   = d[ME_VALID];
    e.ext_any = d[ME_EXT_ANY];
    e.code    = d[ME_CODE_HI:ME_CODE_LO];
    e.player  = d[ME_PLAYER_HI:ME_PLAYER_LO];
    e.button  = d[ME_BTN_HI:ME_BTN_LO];
    return e;
  endfunction

  // ext_any lets one entry catch both the plain and the E0-prefixed code
  function automatic logic entry_match(map_entry_t e, logic [8:0] code);
    return e.valid && (e.code[7:0] == code[7:0]) &&
           (e.ext_any || (e.code[8] == code[8]));
  endfunction

endpackage

// File: rtl/input_pulse_shaper.sv
// Per-button output shaping: coin pulse stretch (no retrigger) or autofire
// gating against the shared phase bit.
module input_pulse_shaper #(
  parameter int COIN_PULSE = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic phase,
  input  logic is_coin,
  input  logic af_en,
  input  logic raw,
  output logic shaped
);
  localparam int CW = $clog2(COIN_PULSE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;

  always_comb begin
    prev_d = raw;
    cnt_d  = cnt_q;
    if (is_coin && raw && !prev_q && (cnt_q == '0)) cnt_d = CW'(COIN_PULSE);
    else if (frame_tick && (cnt_q != '0))          cnt_d = cnt_q - 1'b1;

    shaped = raw;
    if (is_coin)    shaped = (cnt_q != '0);
    else if (af_en) shaped = raw & phase;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick to cabinet button mapper: one-deep PS/2 event slot, serial
// keymap scan, per-player merge, coin stretch and autofire.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BTNS    = 8,
  parameter int MAP_DEPTH   = 32,
  parameter int COIN_PULSE  = 4,
  parameter int AF_DIV      = 3
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [10:0]                     ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]       joy_in,
  input  logic                            joy_merge,
  input  logic                            frame_tick,
  input  logic [NUM_PLAYERS*NUM_BTNS-1:0] af_en,
  input  logic                            map_we,
  input  logic [$clog2(MAP_DEPTH)-1:0]    map_addr,
  input  logic [15:0]                     map_data,
  output logic [NUM_PLAYERS*NUM_BTNS-1:0] btn_out,
  output logic                            evt_ovf
);
  localparam int AW  = $clog2(MAP_DEPTH);
  localparam int NB  = NUM_PLAYERS * NUM_BTNS;
  localparam int AFW = $clog2(AF_DIV + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic            tgl_q, tgl_d;
  logic            pend_vld_q, pend_vld_d;
  logic [9:0]      pend_q, pend_d, work_q, work_d;
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;
  map_entry_t      map_q [MAP_DEPTH];
  map_entry_t      map_d [MAP_DEPTH];
  logic [MAP_DEPTH-1:0] pr_q, pr_d, hit_q, hit_d;
  logic            load;

  logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] kbd, raw, coin_mask;
  logic [NUM_BTNS-1:0] joy_any;
  logic                unused_joy_hi;
  logic [NB-1:0]       raw_flat, coin_flat, shaped, btn_q, btn_d;
  logic                af_act, phase_q, phase_d;
  logic [AFW-1:0]      af_cnt_q, af_cnt_d;

  always_comb begin
    tgl_d      = ps2_key[10];
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    work_d     = work_q;
    state_d    = state_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    map_d      = map_q;
    pr_d       = pr_q;
    hit_d      = hit_q;
    load       = (state_q == ST_IDLE) && pend_vld_q;

    if (load) begin
      work_d     = pend_q;
      pend_vld_d = 1'b0;
      idx_d      = '0;
      hit_d      = '0;
      state_d    = ST_SCAN;
    end

    // the slot frees this cycle on load, so a new event can take it
    if (ps2_key[10] != tgl_q) begin
      if (pend_vld_q && !load) ovf_d = 1'b1;
      else begin
        pend_vld_d = 1'b1;
        pend_d     = ps2_key[9:0];
      end
    end

    // matches are collected and committed together on the last scan cycle
    if (state_q == ST_SCAN) begin
      if (entry_match(map_q[idx_q], work_q[8:0])) hit_d[idx_q] = 1'b1;
      if (idx_q == AW'(MAP_DEPTH - 1)) begin
        state_d = ST_IDLE;
        for (int e = 0; e < MAP_DEPTH; e++)
          if (hit_d[e]) pr_d[e] = work_q[9];
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (map_we) begin
      map_d[map_addr] = unpack_entry(map_data);
      pr_d[map_addr]  = 1'b0;
      hit_d[map_addr] = 1'b0;
    end
  end

  always_comb begin
    kbd = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int b = 0; b < NUM_BTNS; b++)
        for (int e = 0; e < MAP_DEPTH; e++)
          if (map_q[e].valid && pr_q[e] && (int'(map_q[e].player) == p) &&
              (int'(map_q[e].button) == b))
            kbd[p][b] = 1'b1;
  end

  always_comb begin
    joy_any       = '0;
    unused_joy_hi = 1'b0;
    coin_mask     = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_any       = joy_any | joy_in[16*p +: NUM_BTNS];
      unused_joy_hi = unused_joy_hi ^ (^joy_in[16*p+NUM_BTNS +: 16-NUM_BTNS]);
      coin_mask[p][BTN_COIN] = 1'b1;
    end
    for (int p = 0; p < NUM_PLAYERS; p++)
      raw[p] = kbd[p] | (joy_merge ? joy_any : joy_in[16*p +: NUM_BTNS]);
  end

  assign raw_flat  = raw;
  assign coin_flat = coin_mask;

  // coin buttons are never autofired and do not hold the phase
  always_comb begin
    af_act   = |(raw_flat & af_en & ~coin_flat);
    phase_d  = phase_q;
    af_cnt_d = af_cnt_q;
    if (!af_act) begin
      phase_d  = 1'b1;
      af_cnt_d = '0;
    end else if (frame_tick) begin
      if (af_cnt_q == AFW'(AF_DIV - 1)) begin
        af_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        af_cnt_d = af_cnt_q + 1'b1;
      end
    end
  end

  input_pulse_shaper #(.COIN_PULSE(COIN_PULSE)) u_shp [NB-1:0] (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .phase      (phase_q),
    .is_coin    (coin_flat),
    .af_en      (af_en),
    .raw        (raw_flat),
    .shaped     (shaped)
  );

  always_comb btn_d = shaped;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tgl_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      work_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      for (int e = 0; e < MAP_DEPTH; e++) map_q[e] <= '0;
      pr_q       <= '0;
      hit_q      <= '0;
      phase_q    <= 1'b1;
      af_cnt_q   <= '0;
      btn_q      <= '0;
    end else begin
      tgl_q      <= tgl_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      work_q     <= work_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      map_q      <= map_d;
      pr_q       <= pr_d;
      hit_q      <= hit_d;
      phase_q    <= phase_d;
      af_cnt_q   <= af_cnt_d;
      btn_q      <= btn_d;
    end
  end

  assign btn_out = btn_q;
  assign evt_ovf = ovf_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus randomized traffic,
// every cycle compared against an event-level behavioural model.
module tb_arcade_input_mapper;
  localparam int P  = 2;
  localparam int B  = 8;
  localparam int M  = 32;
  localparam int CP = 4;
  localparam int AD = 3;
  localparam int NB = P * B;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic [10:0]     ps2_key = '0;
  logic [16*P-1:0] joy_in = '0;
  logic            joy_merge = 1'b0;
  logic            frame_tick = 1'b0;
  logic [NB-1:0]   af_en = '0;
  logic            map_we = 1'b0;
  logic [4:0]      map_addr = '0;
  logic [15:0]     map_data = '0;
  logic [NB-1:0]   btn_out;
  logic            evt_ovf;

  arcade_input_mapper #(.NUM_PLAYERS(P), .NUM_BTNS(B), .MAP_DEPTH(M),
                        .COIN_PULSE(CP), .AF_DIV(AD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
    .joy_merge(joy_merge), .frame_tick(frame_tick), .af_en(af_en),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .btn_out(btn_out), .evt_ovf(evt_ovf));

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk = 1'b0;

  // reference model state: keymap table, key states, coin timers, AF phase
  bit          m_v[M], m_x[M], m_pr[M];
  bit [8:0]    m_c[M];
  int          m_pl[M], m_bt[M];
  int          m_cnt[NB];
  bit          m_prev[NB];
  bit          m_phase;
  int          m_div;
  bit          m_tgl;
  int          m_cd;
  bit [9:0]    m_evt;
  logic [NB-1:0] exp_btn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < M; e++) begin
      m_v[e] = 0; m_x[e] = 0; m_pr[e] = 0; m_c[e] = 0; m_pl[e] = 0; m_bt[e] = 0;
    end
    for (int i = 0; i < NB; i++) begin m_cnt[i] = 0; m_prev[i] = 0; end
    m_phase = 1; m_div = 0; m_tgl = 0; m_cd = 0; m_evt = 0; exp_btn = '0;
  endtask

  function automatic bit m_kbd(int p, int b);
    for (int e = 0; e < M; e++)
      if (m_v[e] && m_pr[e] && m_pl[e] == p && m_bt[e] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic [NB-1:0] raw, nxt;
    bit any_af, jb;
    int i, e;
    raw = '0; nxt = '0; any_af = 0;
    for (int p = 0; p < P; p++)
      for (int b = 0; b < B; b++) begin
        i = p * B + b;
        jb = 0;
        if (joy_merge) begin
          for (int q = 0; q < P; q++) jb = jb | joy_in[16*q+b];
        end else jb = joy_in[16*p+b];
        raw[i] = m_kbd(p, b) | jb;
        if (b == 7) begin
          nxt[i] = (m_cnt[i] != 0);
          if (raw[i] && !m_prev[i] && m_cnt[i] == 0) m_cnt[i] = CP;
          else if (frame_tick && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          m_prev[i] = raw[i];
        end else begin
          nxt[i] = af_en[i] ? (raw[i] & m_phase) : raw[i];
          any_af = any_af | (af_en[i] & raw[i]);
        end
      end
    if (!any_af) begin m_phase = 1; m_div = 0; end
    else if (frame_tick) begin
      m_div = m_div + 1;
      if (m_div == AD) begin m_div = 0; m_phase = !m_phase; end
    end
    exp_btn = nxt;
    // key event becomes visible after capture, load and a full table scan
    if (m_cd > 0) begin
      m_cd = m_cd - 1;
      if (m_cd == 0)
        for (int k = 0; k < M; k++)
          if (m_v[k] && m_c[k][7:0] == m_evt[7:0] && (m_x[k] || m_c[k][8] == m_evt[8]))
            m_pr[k] = m_evt[9];
    end
    if (map_we) begin
      e = int'(map_addr);
      m_v[e] = map_data[15]; m_x[e] = map_data[14]; m_c[e] = map_data[13:5];
      m_pl[e] = int'(map_data[4:3]); m_bt[e] = int'(map_data[2:0]); m_pr[e] = 0;
    end
    if (ps2_key[10] != m_tgl) begin m_evt = ps2_key[9:0]; m_cd = M + 1; end
    m_tgl = ps2_key[10];
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) model_reset(); else model_edge();
    @(negedge clk_sys);
    if (chk) begin
      check("btn", btn_out, exp_btn);
      check("ovf", evt_ovf, 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [15:0] mk(bit v, bit x, bit [8:0] c, bit [1:0] pl, bit [2:0] bt);
    return {v, x, c, pl, bt};
  endfunction

  task automatic wmap(input int addr, input logic [15:0] d);
    map_we = 1'b1; map_addr = addr[4:0]; map_data = d;
    tick();
    map_we = 1'b0;
  endtask

  task automatic send_key(input bit pr, input bit [8:0] code);
    bit t;
    t = !ps2_key[10];
    ps2_key = {t, pr, code};
  endtask

  initial begin
    bit [8:0]  codes[5];
    int        hi;
    logic [11:0] pat, exp_pat;
    codes[0] = 9'h075; codes[1] = 9'h175; codes[2] = 9'h029; codes[3] = 9'h01C; codes[4] = 9'h11C;
    model_reset();
    ticks(3);
    check("rst_btn", btn_out, 0);
    check("rst_ovf", evt_ovf, 0);
    reset_n = 1'b1; chk = 1'b1;
    ticks(2);

    // ext_any entry, exact key latency
    wmap(0, mk(1, 1, 9'h075, 0, 3));
    send_key(1, 9'h175);
    ticks(M + 2);
    check("lat_early", btn_out[3], 0);
    tick();
    check("lat_hit", btn_out[3], 1);
    send_key(0, 9'h175);
    ticks(M + 4);
    check("rel_up", btn_out[3], 0);

    // one code driving two players
    wmap(1, mk(1, 0, 9'h029, 0, 5));
    wmap(2, mk(1, 0, 9'h029, 1, 5));
    send_key(1, 9'h029);
    ticks(M + 4);
    check("multi_p0", btn_out[5], 1);
    check("multi_p1", btn_out[13], 1);
    send_key(0, 9'h029);
    ticks(M + 4);
    check("multi_rel", {btn_out[13], btn_out[5]}, 0);

    // joystick merge vs per-player
    joy_merge = 1'b1; joy_in = 32'h0010_0000;
    ticks(2);
    check("merge_p0", btn_out[4], 1);
    check("merge_p1", btn_out[12], 1);
    joy_merge = 1'b0;
    ticks(2);
    check("sep_p0", btn_out[4], 0);
    check("sep_p1", btn_out[12], 1);
    joy_in = '0;
    ticks(2);

    // coin stretch, second press inside the window is ignored
    joy_in[7] = 1'b1; tick(); joy_in[7] = 1'b0;
    ticks(2);
    hi = 0;
    for (int f = 0; f < 10; f++) begin
      if (btn_out[7]) hi++;
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      ticks(4);
      if (f == 0) begin joy_in[7] = 1'b1; tick(); joy_in[7] = 1'b0; ticks(2); end
    end
    check("coin_frames", hi, CP);

    // autofire on p0 fire
    af_en[4] = 1'b1; joy_in[4] = 1'b1;
    ticks(2);
    pat = '0; exp_pat = '0;
    for (int f = 0; f < 12; f++) begin
      pat[f] = btn_out[4];
      exp_pat[f] = ((f / AD) % 2) == 0;
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      ticks(4);
    end
    check("af_pattern", pat, exp_pat);
    joy_in[4] = 1'b0; af_en = '0;
    ticks(3);
    check("af_rel", btn_out[4], 0);

    // randomized traffic, events spaced beyond one full scan
    for (int it = 0; it < 40; it++) begin
      joy_in = $urandom & $urandom & $urandom;
      joy_merge = $urandom_range(0, 1);
      af_en = NB'($urandom & $urandom);
      if ($urandom_range(0, 1) == 1)
        wmap($urandom_range(0, M - 1),
             mk($urandom_range(0, 7) != 0, $urandom_range(0, 1), codes[$urandom_range(0, 4)],
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))));
      send_key($urandom_range(0, 1), codes[$urandom_range(0, 4)]);
      for (int c = 0; c < M + 8; c++) begin
        frame_tick = ($urandom_range(0, 3) == 0);
        tick();
        frame_tick = 1'b0;
      end
    end
    joy_in = '0; af_en = '0; joy_merge = 1'b0;
    ticks(6);

    // event buffering and overflow
    for (int e = 0; e < M; e++) wmap(e, 16'h0);
    wmap(0, mk(1, 1, 9'h075, 0, 3));
    wmap(1, mk(1, 0, 9'h029, 0, 5));
    ticks(2);
    chk = 1'b0;
    send_key(1, 9'h175); ticks(4);
    send_key(1, 9'h029); ticks(4);
    send_key(0, 9'h175); ticks(2 * M + 12);
    check("ovf_first", btn_out[3], 1);
    check("ovf_second", btn_out[5], 1);
    check("ovf_flag", evt_ovf, 1);

    // reset in the middle of a scan
    send_key(0, 9'h029);
    ticks(10);
    reset_n = 1'b0; ps2_key = '0;
    model_reset();
    #1;
    check("rst_mid_btn", btn_out, 0);
    check("rst_mid_ovf", evt_ovf, 0);
    ticks(3);
    reset_n = 1'b1; chk = 1'b1;
    ticks(4);
    send_key(1, 9'h175);
    ticks(M + 4);
    check("clr_a", btn_out[3], 0);
    send_key(1, 9'h029);
    ticks(M + 4);
    check("clr_b", btn_out[5], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
